// File: rtl/osc_cal_pkg.sv
// Shared types and constants for the oscillator trim calibration block.
package osc_cal_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StDisc,
    StMeas,
    StDecide,
    StFdisc,
    StFmeas,
    StFin
  } cal_state_e;

  localparam logic [5:0]  TRIM_DEF_C = 6'h20;
  localparam int unsigned TOUT_CYC_C = 1024;
  localparam int unsigned TOUT_W     = 16;

  // Absolute difference widened to 17 bits so it never wraps.
  function automatic logic [16:0] abs_diff(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] ea, eb;
    ea = {1'b0, a};
    eb = {1'b0, b};
    return (ea >= eb) ? (ea - eb) : (eb - ea);
  endfunction

endpackage

// File: rtl/osc_cal_tstop_sync.sv
// Two-flop synchroniser for the TSTOP toggle plus a history flop; EVT marks either edge.
module tstop_sync (
  input  logic ECLK,
  input  logic RSTN,
  input  logic TSTOP,
  output logic EVT,
  output logic TLVL
);

  logic s1_q, s2_q, hist_q;

  always_ff @(posedge ECLK) begin
    if (!RSTN) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      hist_q <= 1'b0;
    end else begin
      s1_q   <= TSTOP;
      s2_q   <= s1_q;
      hist_q <= s2_q;
    end
  end

  assign EVT  = s2_q ^ hist_q;
  assign TLVL = s2_q;

endmodule

// File: rtl/osc_cal.sv
// Successive-approximation trim calibration: each trim bit is decided from one counted
// measurement window taken after a discarded settling window.
module osc_cal
  import osc_cal_pkg::*;
#(
  parameter int unsigned         TRIM_W   = 6,
  parameter logic [TRIM_W-1:0]   TRIM_DEF = TRIM_W'(TRIM_DEF_C),
  parameter int unsigned         TOUT_CYC = TOUT_CYC_C
) (
  input  logic              ECLK,
  input  logic              RSTN,
  input  logic              START,
  input  logic [15:0]       TARGET,
  input  logic [7:0]        TOL,
  input  logic              TSTOP,
  input  logic [15:0]       TVAL,
  output logic [TRIM_W-1:0] TRIM,
  output logic              BUSY,
  output logic              DONE,
  output logic              LOCK,
  output logic              TERR
);

  localparam int unsigned IDX_W = (TRIM_W > 1) ? $clog2(TRIM_W) : 1;

  cal_state_e        state_q, state_d;
  logic [TRIM_W-1:0] trim_q, trim_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [TOUT_W-1:0] cnt_q, cnt_d;
  logic [15:0]       tcap_q;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              lock_q, lock_d;
  logic              terr_q, terr_d;
  logic              pend_q, pend_d;
  logic              evt, tlvl_unused;
  logic              in_wait, tout_hit, timeout;

  tstop_sync u_tstop_sync (
    .ECLK  (ECLK),
    .RSTN  (RSTN),
    .TSTOP (TSTOP),
    .EVT   (evt),
    .TLVL  (tlvl_unused)
  );

  assign in_wait  = state_q inside {StDisc, StMeas, StFdisc, StFmeas};
  assign tout_hit = in_wait && (cnt_q == TOUT_W'(TOUT_CYC - 1));

  always_comb begin
    state_d = state_q;
    trim_d  = trim_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    lock_d  = lock_q;
    terr_d  = terr_q;
    pend_d  = pend_q;
    timeout = 1'b0;
    unique case (state_q)
      StIdle: begin
        pend_d = 1'b0;
        if (START) begin
          lock_d             = 1'b0;
          terr_d             = 1'b0;
          busy_d             = 1'b1;
          trim_d             = '0;
          trim_d[TRIM_W-1]   = 1'b1;
          idx_d              = IDX_W'(TRIM_W - 1);
          state_d            = StDisc;
        end
      end
      StDisc, StFdisc: begin
        // An event held over from DECIDE serves as this window's discard.
        if (pend_q && evt) begin
          pend_d  = 1'b0;
          state_d = (state_q == StDisc) ? StDecide : StFin;
        end else if (pend_q || evt) begin
          pend_d  = 1'b0;
          state_d = (state_q == StDisc) ? StMeas : StFmeas;
        end else if (tout_hit) begin
          timeout = 1'b1;
        end
      end
      StMeas, StFmeas: begin
        if (evt) begin
          state_d = (state_q == StMeas) ? StDecide : StFin;
        end else if (tout_hit) begin
          timeout = 1'b1;
        end
      end
      StDecide: begin
        if (evt) begin
          pend_d = 1'b1;
        end
        if (tcap_q > TARGET) begin
          trim_d[idx_q] = 1'b0;
        end
        if (idx_q != '0) begin
          trim_d[idx_q - IDX_W'(1)] = 1'b1;
          idx_d                     = idx_q - IDX_W'(1);
          state_d                   = StDisc;
        end else begin
          state_d = StFdisc;
        end
      end
      StFin: begin
        lock_d  = abs_diff(tcap_q, TARGET) <= {9'd0, TOL};
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (timeout) begin
      terr_d  = 1'b1;
      lock_d  = 1'b0;
      trim_d  = TRIM_DEF;
      done_d  = 1'b1;
      busy_d  = 1'b0;
      pend_d  = 1'b0;
      state_d = StIdle;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (evt || (state_d != state_q)) begin
      cnt_d = '0;
    end else if (in_wait) begin
      cnt_d = cnt_q + TOUT_W'(1);
    end
  end

  always_ff @(posedge ECLK) begin
    if (!RSTN) begin
      state_q <= StIdle;
      trim_q  <= TRIM_DEF;
      idx_q   <= '0;
      cnt_q   <= '0;
      tcap_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      lock_q  <= 1'b0;
      terr_q  <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      trim_q  <= trim_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      lock_q  <= lock_d;
      terr_q  <= terr_d;
      pend_q  <= pend_d;
      if (evt) begin
        tcap_q <= TVAL;
      end
    end
  end

  assign TRIM = trim_q;
  assign BUSY = busy_q;
  assign DONE = done_q;
  assign LOCK = lock_q;
  assign TERR = terr_q;

endmodule

// File: tb/tb_osc_cal.sv
// Bench for osc_cal: oscillator plant TVAL = 1000 + 20*TRIM, TSTOP toggled every 512 cycles.
module tb_osc_cal;

  logic        ECLK = 1'b0;
  logic        RSTN = 1'b0;
  logic        START = 1'b0;
  logic        TSTOP = 1'b0;
  logic [15:0] TARGET = '0;
  logic [7:0]  TOL = '0;
  logic [15:0] TVAL;
  logic [5:0]  TRIM;
  logic        BUSY, DONE, LOCK, TERR;

  always #5 ECLK = ~ECLK;

  assign TVAL = 16'(1000 + 20 * int'(TRIM));

  osc_cal dut (
    .ECLK   (ECLK),
    .RSTN   (RSTN),
    .START  (START),
    .TARGET (TARGET),
    .TOL    (TOL),
    .TSTOP  (TSTOP),
    .TVAL   (TVAL),
    .TRIM   (TRIM),
    .BUSY   (BUSY),
    .DONE   (DONE),
    .LOCK   (LOCK),
    .TERR   (TERR)
  );

  int cyc = 0;
  always @(posedge ECLK) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Plain binary search over the trim code against the plant law.
  int m_trials[$];
  int m_final;
  int m_lock;

  function automatic void model(input int target, input int tol);
    int r, t, d;
    m_trials.delete();
    r = 0;
    for (int b = 5; b >= 0; b--) begin
      t = r | (1 << b);
      m_trials.push_back(t);
      if (1000 + 20 * t <= target) r = t;
    end
    m_final = r;
    d = 1000 + 20 * r - target;
    if (d < 0) d = -d;
    m_lock = (d <= tol) ? 1 : 0;
  endfunction

  // Per-cycle comparison against the expected run window.
  bit chk_en = 1'b0;
  int exp_start, exp_done, exp_trim, exp_lock, exp_terr;

  always @(negedge ECLK) begin
    if (chk_en) begin
      check("done", int'(DONE), int'(cyc == exp_done));
      check("busy", int'(BUSY), int'(cyc > exp_start && cyc < exp_done));
      if (cyc >= exp_done) begin
        check("trim_final", int'(TRIM), exp_trim);
        check("lock_final", int'(LOCK), exp_lock);
        check("terr_final", int'(TERR), exp_terr);
      end
    end
  end

  task automatic step();
    @(posedge ECLK);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step();
  endtask

  // One calibration with n_ev TSTOP toggles; fewer than 14 toggles means a timeout.
  task automatic run_cal(input int target, input int tol, input int n_ev);
    int s, last_t, tc;
    bit to;
    to = (n_ev < 14);
    model(target, tol);
    TARGET = 16'(target);
    TOL    = 8'(tol);
    step();
    s         = cyc;
    last_t    = s + 100 + 512 * (n_ev - 1);
    exp_start = s;
    exp_done  = to ? last_t + 1027 : last_t + 4;
    exp_trim  = to ? 32'h20 : m_final;
    exp_lock  = to ? 0 : m_lock;
    exp_terr  = to ? 1 : 0;
    chk_en    = 1'b1;
    START     = 1'b1;
    step();
    START = 1'b0;
    for (int k = 0; k < n_ev; k++) begin
      tc = s + 100 + 512 * k;
      wait_until(tc);
      if (k % 2 == 1) begin
        check("trim_meas", int'(TRIM), (k == 13) ? m_final : m_trials[k / 2]);
      end
      TSTOP = ~TSTOP;
    end
    wait_until(exp_done + 3);
    chk_en = 1'b0;
  endtask

  task automatic reset_abort();
    int s;
    TARGET = 16'd1650;
    TOL    = 8'd15;
    step();
    s         = cyc;
    exp_start = s;
    exp_done  = s + 1000000;
    chk_en    = 1'b1;
    START     = 1'b1;
    step();
    START = 1'b0;
    wait_until(s + 100);
    TSTOP = ~TSTOP;
    wait_until(s + 612);
    TSTOP = ~TSTOP;
    wait_until(s + 640);
    check("trim_bit4_trial", int'(TRIM), 48);
    START = 1'b1;
    step();
    START = 1'b0;
    repeat (5) step();
    check("start_while_busy_trim", int'(TRIM), 48);
    wait_until(s + 1124);
    TSTOP = ~TSTOP;
    wait_until(s + 1150);
    chk_en = 1'b0;
    RSTN   = 1'b0;
    step();
    check("rst_trim", int'(TRIM), 32'h20);
    check("rst_busy", int'(BUSY), 0);
    check("rst_lock", int'(LOCK), 0);
    check("rst_terr", int'(TERR), 0);
    for (int i = 0; i < 3; i++) begin
      check("rst_no_done", int'(DONE), 0);
      step();
    end
    RSTN = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      check("post_rst_no_done", int'(DONE), 0);
      check("post_rst_busy", int'(BUSY), 0);
    end
  endtask

  initial begin
    RSTN = 1'b0;
    repeat (4) step();
    check("reset_trim", int'(TRIM), 32'h20);
    check("reset_busy", int'(BUSY), 0);
    check("reset_done", int'(DONE), 0);
    check("reset_lock", int'(LOCK), 0);
    check("reset_terr", int'(TERR), 0);
    RSTN = 1'b1;
    repeat (3) step();

    model(1650, 15);
    check("model_trial0", m_trials[0], 32);
    check("model_trial1", m_trials[1], 48);
    check("model_trial2", m_trials[2], 40);
    check("model_trial5", m_trials[5], 33);
    check("model_final_1650", m_final, 32);
    check("model_lock_tol15", m_lock, 1);
    model(1650, 5);
    check("model_lock_tol5", m_lock, 0);
    model(65535, 15);
    check("model_final_ffff", m_final, 63);
    model(0, 15);
    check("model_final_0", m_final, 0);

    run_cal(1650, 15, 14);
    run_cal(1650, 5, 14);
    run_cal(65535, 15, 14);
    run_cal(0, 15, 14);
    run_cal(1650, 15, 3);
    reset_abort();
    run_cal(1650, 15, 14);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/osc_cal.md
OSC_CAL -- requirements
Module: osc_cal

Interface
REQ-001 Parameter TRIM_W, default 6, SHALL set the oscillator trim code width.
REQ-002 Parameter TRIM_DEF, default 6'h20, SHALL set the trim code used at reset, idle and after a timeout.
REQ-003 Parameter TOUT_CYC, default 1024, SHALL set the ECLK cycles allowed between measurement events.
REQ-004 ECLK  in  1  SHALL be the sole clock; one clock, all flops on posedge ECLK.
REQ-005 RSTN  in  1  SHALL be the reset: synchronous, active-low.
REQ-006 START  in  1  SHALL be a one-cycle calibration request.
REQ-007 TARGET  in  16  SHALL be the desired count per measurement window.
REQ-008 TOL  in  8  SHALL be the lock tolerance in counts.
REQ-009 TSTOP  in  1  SHALL be the asynchronous measurement-end toggle from the tag clock monitor.
REQ-010 TVAL  in  16  SHALL be the quasi-static count from the tag clock monitor.
REQ-011 TRIM  out  TRIM_W  SHALL be the oscillator trim code.
REQ-012 BUSY  out  1  SHALL be high while a calibration is running.
REQ-013 DONE  out  1  SHALL be a one-cycle pulse at calibration end, successful or not.
REQ-014 LOCK  out  1  SHALL indicate that the final count is within TOL of TARGET.
REQ-015 TERR  out  1  SHALL indicate that the last calibration timed out.

Function
REQ-016 TSTOP SHALL pass through a 2-flop synchroniser plus one history flop; EVT = sync2 XOR hist, and either edge counts as one event.
REQ-017 On the EVT cycle, TVAL SHALL be captured into TCAP; no other capture point is permitted.
REQ-018 The FSM states SHALL be: IDLE, DISC, MEAS, DECIDE, FDISC, FMEAS and FIN.
REQ-019 IDLE: on START, the block SHALL clear LOCK and TERR, set BUSY, set TRIM = 1 at MSB with all other bits 0, set bit index to TRIM_W-1, and go to DISC.
REQ-020 DISC: the first EVT after any TRIM change SHALL be discarded (settling window) and the FSM SHALL go to MEAS.
REQ-021 MEAS: on EVT, the block SHALL capture TCAP and go to DECIDE.
REQ-022 DECIDE (1 cycle): if TCAP > TARGET, TRIM[index] SHALL be cleared; otherwise it SHALL be kept.
REQ-023 DECIDE, index > 0: the block SHALL set TRIM[index-1], decrement index and go to DISC.
REQ-024 DECIDE, index = 0: the block SHALL go to FDISC.
REQ-025 FDISC SHALL discard one EVT and go to FMEAS; FMEAS SHALL capture on EVT and go to FIN.
REQ-026 FIN (1 cycle): LOCK SHALL be set to (|TCAP - TARGET| <= TOL), computed on 17 bits without wrap; the block SHALL then pulse DONE, clear BUSY and go to IDLE.
REQ-027 A full run SHALL use exactly 2*(TRIM_W+1) events.
REQ-028 A timeout counter SHALL clear on every EVT and on state entry, and SHALL increment in DISC, MEAS, FDISC and FMEAS.
REQ-029 When the timeout counter reaches TOUT_CYC-1, the block SHALL set TERR=1, LOCK=0, TRIM=TRIM_DEF, pulse DONE, clear BUSY and go to IDLE.
REQ-030 START SHALL be ignored while BUSY=1.
REQ-031 An EVT that arrives in DECIDE or FIN SHALL be counted as the next state's discard event; no event is lost.
REQ-032 TRIM SHALL hold its final value in IDLE until the next START or reset.

Reset
REQ-033 While RSTN=0 at an ECLK edge: TRIM=TRIM_DEF, BUSY=0, DONE=0, LOCK=0, TERR=0, FSM=IDLE, and the counters, TCAP and synchroniser flops SHALL be cleared.
REQ-034 Reset mid-calibration SHALL abort with no DONE pulse.
REQ-035 After release, the first synchronised TSTOP edge SHALL be treated as a normal EVT.

Structure
REQ-036 The FSM state encoding, TRIM_DEF and the TOUT_CYC counter width SHALL live in a shared package, osc_cal_pkg.
REQ-037 The TSTOP synchroniser and edge detector SHALL be one sub-module, tstop_sync, with outputs EVT and the synchronised level.

Verification
Bench model: TVAL = 1000 + 20*TRIM, with a TSTOP toggle every 512 ECLK.
REQ-038 TARGET=1650, TOL=15, START -> TRIM sequence 32,48,40,36,34,33, final TRIM=32 (0x20), LOCK=1, TERR=0, DONE after 14 events.
REQ-039 Same stimulus with TOL=5 -> TRIM=32, LOCK=0 (|1640-1650|=10).
REQ-040 TARGET=16'hFFFF -> TRIM=63, LOCK=0; TARGET=0 -> TRIM=0, LOCK=0.
REQ-041 TSTOP frozen after the 3rd event -> TERR=1, TRIM=0x20, DONE pulse 1024 cycles after the last EVT, BUSY=0.
REQ-042 START pulsed while BUSY, then RSTN low in MEAS -> the START has no effect; on reset, TRIM=0x20, BUSY=0, no DONE; a new START after release completes normally.
